// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the uart loader: FSM state encoding and frame geometry.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT,
    ST_SEND,
    ST_SEND_WAIT
  } loader_state_t;

  localparam int CMD_WE_BIT     = 7;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;

endpackage

// File: rtl/uart_loader_if.sv
// Byte stream (uart rx/tx) and instruction-memory port seen by the loader.
interface uart_loader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              mem_re;

  modport master (
    input  rx_data, rx_valid, tx_busy, mem_rdata,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mem_rdata,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/uart_loader_timer.sv
// Inter-byte watchdog: counts while enabled, saturates at MAX and flags expiry.
module uart_loader_timer #(
  parameter int MAX = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_loader_ctrl.sv
// Host byte-stream command sequencer driving the instruction memory port.
// Optional inter-byte write timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_loader_ctrl
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic           clk,
  input  logic           reset,
  uart_loader_if.master  bus,
  output logic           busy,
  output logic           cmd_done,
  output logic           rx_overrun,
  output logic           err_timeout
);
  loader_state_t     st_q, st_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic guard_q, guard_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d, tx_valid_q, tx_valid_d;
  logic cmd_done_q, cmd_done_d, rx_overrun_q, rx_overrun_d, err_timeout_q, err_timeout_d;
  logic tmr_expired;

`ifdef LOADER_TIMEOUT_EN
  logic tmr_clr;
  // Restart on the command byte that opens a write frame and on every data byte.
  assign tmr_clr = bus.rx_valid &&
                   ((st_q == ST_IDLE && bus.rx_data[CMD_WE_BIT]) || st_q == ST_COLLECT);

  uart_loader_timer #(.MAX(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (st_q == ST_COLLECT),
    .expired(tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  always_comb begin
    st_d          = st_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    guard_d       = guard_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tx_data_d     = tx_data_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    tx_valid_d    = 1'b0;
    cmd_done_d    = 1'b0;
    err_timeout_d = 1'b0;
    rx_overrun_d  = rx_overrun_q;

    if (bus.rx_valid && !(st_q inside {ST_IDLE, ST_COLLECT})) rx_overrun_d = 1'b1;

    // Strobes are set on entry to WRITE/READ so they are high in that state's cycle.
    unique case (st_q)
      ST_IDLE: if (bus.rx_valid) begin
        addr_d = bus.rx_data[ADDR_W-1:0];
        idx_d  = '0;
        if (bus.rx_data[CMD_WE_BIT]) begin
          st_d = ST_COLLECT;
        end else begin
          st_d       = ST_READ;
          mem_re_d   = 1'b1;
          mem_addr_d = bus.rx_data[ADDR_W-1:0];
        end
      end
      ST_COLLECT: begin
        if (bus.rx_valid) begin
          wdata_d[8*idx_q +: 8] = bus.rx_data;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
            st_d        = ST_WRITE;
            idx_d       = '0;
            mem_we_d    = 1'b1;
            cmd_done_d  = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata_d;
          end
        end else if (tmr_expired) begin
          st_d          = ST_IDLE;
          idx_d         = '0;
          wdata_d       = '0;
          err_timeout_d = 1'b1;
        end
      end
      ST_WRITE:     st_d = ST_IDLE;
      ST_READ:      st_d = ST_READ_WAIT;
      ST_READ_WAIT: begin
        rdata_d = bus.mem_rdata;
        idx_d   = '0;
        st_d    = ST_SEND;
      end
      ST_SEND: if (!bus.tx_busy) begin
        tx_valid_d = 1'b1;
        tx_data_d  = rdata_q[8*idx_q +: 8];
        guard_d    = 1'b1;
        st_d       = ST_SEND_WAIT;
      end
      ST_SEND_WAIT: begin
        // The transmitter raises tx_busy one cycle after tx_valid; skip that cycle.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!bus.tx_busy) begin
          if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
            cmd_done_d = 1'b1;
            st_d       = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            st_d  = ST_SEND;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q          <= ST_IDLE;
      idx_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      guard_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      cmd_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      st_q          <= st_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      guard_q       <= guard_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tx_data_q     <= tx_data_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      tx_valid_q    <= tx_valid_d;
      cmd_done_q    <= cmd_done_d;
      err_timeout_q <= err_timeout_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign busy          = (st_q != ST_IDLE);
  assign cmd_done      = cmd_done_q;
  assign rx_overrun    = rx_overrun_q;
  assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Scoreboard bench for uart_loader_ctrl: directed host frames, monitor pops expected strobes/bytes.
module tb_uart_loader_ctrl;
  localparam int TB_TMO = 60;
  localparam logic [31:0] K_WE = 0, K_RE = 1, K_TX = 2, K_DONE = 3, K_TMO = 4;

  typedef struct packed {
    logic [31:0] kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, cmd_done, rx_overrun, err_timeout;
  int checks = 0;
  int passes = 0;
  ev_t exp_q[$];

  uart_loader_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  uart_loader_ctrl #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .cmd_done   (cmd_done),
    .rx_overrun (rx_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Memory: returns rd_word the cycle after mem_re, junk otherwise to expose a mistimed capture.
  logic [31:0] rd_word = 32'h0;
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= rd_word;
    else            bus.mem_rdata <= 32'h0BAD0BAD;
  end

  // Transmitter: busy for tx_len cycles starting the cycle after tx_valid.
  int   tx_len = 6;
  int   tx_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (bus.tx_valid)    tx_cnt <= tx_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = force_busy || (tx_cnt != 0);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  task automatic sb_pop(input logic [31:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL sb_unexpected: got kind %0d a=%h d=%h, want no event", k, a, d);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_kind", k, e.kind);
    chk("sb_addr", a, e.a);
    chk("sb_data", d, e.d);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_we || bus.mem_re) chk("we_re_excl", {31'h0, bus.mem_we & bus.mem_re}, 32'h0);
      if (bus.mem_we) sb_pop(K_WE, {25'h0, bus.mem_addr}, bus.mem_wdata);
      if (bus.mem_re) sb_pop(K_RE, {25'h0, bus.mem_addr}, 32'h0);
      if (bus.tx_valid) begin
        chk("tx_while_busy", {31'h0, bus.tx_busy}, 32'h0);
        sb_pop(K_TX, 32'h0, {24'h0, bus.tx_data});
      end
      if (cmd_done)    sb_pop(K_DONE, 32'h0, 32'h0);
      if (err_timeout) sb_pop(K_TMO, 32'h0, 32'h0);
    end
  end

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: K_WE, a: a, d: d});
    exp_q.push_back('{kind: K_DONE, a: 32'h0, d: 32'h0});
  endtask

  task automatic push_read(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: K_RE, a: a, d: 32'h0});
    for (int i = 0; i < 4; i++) exp_q.push_back('{kind: K_TX, a: 32'h0, d: {24'h0, d[8*i +: 8]}});
    exp_q.push_back('{kind: K_DONE, a: 32'h0, d: 32'h0});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      {31'h0, busy},        32'h0);
    chk({tag, "_cmd_done"},  {31'h0, cmd_done},    32'h0);
    chk({tag, "_overrun"},   {31'h0, rx_overrun},  32'h0);
    chk({tag, "_err_tmo"},   {31'h0, err_timeout}, 32'h0);
    chk({tag, "_tx_valid"},  {31'h0, bus.tx_valid}, 32'h0);
    chk({tag, "_tx_data"},   {24'h0, bus.tx_data},  32'h0);
    chk({tag, "_mem_we"},    {31'h0, bus.mem_we},   32'h0);
    chk({tag, "_mem_re"},    {31'h0, bus.mem_re},   32'h0);
    chk({tag, "_mem_addr"},  {25'h0, bus.mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,         32'h0);
  endtask

  initial begin
    bus.rx_data  = 8'h0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Read of addr 5 returning DEADBEEF, bytes LSB first.
    rd_word = 32'hDEADBEEF;
    push_read(32'd5, 32'hDEADBEEF);
    send(8'h05);
    wait_idle(500);

    // Write 0x12345678 to addr 5.
    push_write(32'd5, 32'h12345678);
    send(8'h85); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_idle(100);

    // Transmitter held busy: bytes must wait, none lost or repeated.
    tx_len     = 100;
    force_busy = 1'b1;
    rd_word    = 32'hA1B2C3D4;
    push_read(32'd3, 32'hA1B2C3D4);
    send(8'h03);
    repeat (100) @(negedge clk);
    force_busy = 1'b0;
    wait_idle(2000);

    // Byte arriving mid-reply is dropped and flagged; following command parses normally.
    tx_len  = 20;
    rd_word = 32'hCAFEF00D;
    push_read(32'd10, 32'hCAFEF00D);
    send(8'h0A);
    repeat (8) @(negedge clk);
    send(8'h33);
    wait_idle(1000);
    chk("overrun_set", {31'h0, rx_overrun}, 32'h1);
    push_write(32'h7F, 32'h0BADC0DE);
    send(8'hFF); send(8'hDE); send(8'hC0); send(8'hAD); send(8'h0B);
    wait_idle(100);
    chk("overrun_sticky", {31'h0, rx_overrun}, 32'h1);

`ifdef LOADER_TIMEOUT_EN
    // Abandoned write frame times out without a memory write.
    exp_q.push_back('{kind: K_TMO, a: 32'h0, d: 32'h0});
    send(8'h81); send(8'hAA);
    repeat (TB_TMO + 10) @(negedge clk);
    chk("tmo_idle", {31'h0, busy}, 32'h0);
    rd_word = 32'h55667788;
    push_read(32'd2, 32'h55667788);
    send(8'h02);
    wait_idle(500);
`endif

    // Reset mid-frame aborts it; next write commits only its own bytes.
    tx_len = 6;
    send(8'h83); send(8'h11);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push_write(32'd7, 32'h04030201);
    send(8'h87); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    wait_idle(100);

    repeat (5) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end
endmodule
